// File: rtl/wshbn_pkg.sv
// Shared definitions for the Wishbone timer slave: register offsets, CTRL
// bit positions and the bus handshake state type.
package wshbn_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_COUNT   = 2'd1;
  localparam logic [1:0] REG_COMPARE = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IEN    = 2;
  localparam int CTRL_W      = 3;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Divides the clock into a one-cycle tick every PRESCALE enabled cycles.
module timer_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int             W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0]   LAST = W'(PRESCALE - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // With PRESCALE=1 the counter sits at 0, so the enable alone gates the tick.
  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr || !en || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wshbn_timer_slave.sv
// Wishbone classic slave timer: four-register bus interface plus a prescaled
// 32-bit up-counter with compare-match, reload/one-shot and level interrupt.
module wshbn_timer_slave
  import wshbn_pkg::*;
#(
  parameter int          PRESCALE      = 1,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [7:0]  ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        irq_o
);

  bus_state_e        state_q, state_d;
  logic              accept, wr, ctrl_wr, tick, hit;
  logic [1:0]        reg_sel;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       count_q, count_d;
  logic [31:0]       compare_q, compare_d;
  logic [31:0]       dat_q, dat_d;
  logic              match_q, match_d;
  logic              unused_adr;

  assign reg_sel    = ADR_I[3:2];
  assign unused_adr = ^{ADR_I[7:4], ADR_I[1:0]};
  assign wr         = accept & WE_I;
  assign ctrl_wr    = wr & (reg_sel == REG_CTRL);
  assign hit        = (count_q == compare_q);

  timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (ctrl_q[CTRL_EN]),
    .clr  (ctrl_wr),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (CYC_I && STB_I) begin
          accept  = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Timer update first, bus write last so a same-edge write always wins,
  // except that a match set beats a W1C of STATUS.
  always_comb begin
    ctrl_d    = ctrl_q;
    count_d   = count_q;
    compare_d = compare_q;
    match_d   = match_q;
    dat_d     = dat_q;
    if (wr && (reg_sel == REG_STATUS) && DAT_I[0]) match_d = 1'b0;
    if (tick) begin
      if (hit) begin
        match_d = 1'b1;
        if (ctrl_q[CTRL_RELOAD]) count_d = '0;
        else                     ctrl_d[CTRL_EN] = 1'b0;
      end else begin
        count_d = count_q + 32'd1;
      end
    end
    if (wr) begin
      case (reg_sel)
        REG_CTRL:    ctrl_d    = DAT_I[CTRL_W-1:0];
        REG_COUNT:   count_d   = DAT_I;
        REG_COMPARE: compare_d = DAT_I;
        default:     ;
      endcase
    end
    if (accept && !WE_I) begin
      case (reg_sel)
        REG_CTRL:    dat_d = {{(32-CTRL_W){1'b0}}, ctrl_q};
        REG_COUNT:   dat_d = count_q;
        REG_COMPARE: dat_d = compare_q;
        default:     dat_d = {31'd0, match_q};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      count_q   <= '0;
      compare_q <= RESET_COMPARE;
      match_q   <= 1'b0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      match_q   <= match_d;
      dat_q     <= dat_d;
    end
  end

  assign ACK_O = (state_q == ACK);
  assign DAT_O = dat_q;
  assign irq_o = match_q & ctrl_q[CTRL_IEN];

endmodule

// File: tb/tb_wshbn_timer_slave.sv
// Self-checking bench for wshbn_timer_slave: one instance with PRESCALE=1 and
// one with PRESCALE=4 share the bus; directed scenarios then a random run.
module tb_wshbn_timer_slave;

  localparam logic [7:0] A_CTRL    = 8'h10;
  localparam logic [7:0] A_COUNT   = 8'h14;
  localparam logic [7:0] A_COMPARE = 8'h18;
  localparam logic [7:0] A_STATUS  = 8'h1C;

  logic        clk = 1'b0, rst = 1'b0, cyc = 1'b0, we = 1'b0;
  logic        stb1 = 1'b0, stb4 = 1'b0;
  logic [7:0]  adr = 8'h00;
  logic [31:0] dat_i = 32'h0;
  logic [31:0] dat1, dat4;
  logic        ack1, ack4, irq1, irq4;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  wshbn_timer_slave #(.PRESCALE(1), .RESET_COMPARE(32'hFFFF_FFFF)) dut1 (
    .clk(clk), .rst(rst), .CYC_I(cyc), .STB_I(stb1), .WE_I(we), .ADR_I(adr),
    .DAT_I(dat_i), .DAT_O(dat1), .ACK_O(ack1), .irq_o(irq1));

  wshbn_timer_slave #(.PRESCALE(4), .RESET_COMPARE(32'hFFFF_FFFF)) dut4 (
    .clk(clk), .rst(rst), .CYC_I(cyc), .STB_I(stb4), .WE_I(we), .ADR_I(adr),
    .DAT_I(dat_i), .DAT_O(dat4), .ACK_O(ack4), .irq_o(irq4));

  // ---------------- bus helpers (s: 0 = PRESCALE 1, 1 = PRESCALE 4, 2 = both)
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_start(input int s, input logic w, input logic [7:0] a, input logic [31:0] d);
    cyc = 1'b1; we = w; adr = a; dat_i = d;
    stb1 = (s != 1);
    stb4 = (s != 0);
  endtask

  task automatic bus_end();
    cyc = 1'b0; stb1 = 1'b0; stb4 = 1'b0; we = 1'b0;
  endtask

  task automatic bus_write(input int s, input logic [7:0] a, input logic [31:0] d);
    bus_start(s, 1'b1, a, d);
    step();
    bus_end();
    step();
  endtask

  task automatic bus_read(input int s, input logic [7:0] a, output logic [31:0] d, output logic k);
    bus_start(s, 1'b0, a, 32'h0);
    step();
    d = (s == 1) ? dat4 : dat1;
    k = (s == 1) ? ack4 : ack1;
    bus_end();
    step();
  endtask

  // ---------------- behavioural reference model for the random run
  logic [2:0]  m_ctrl[2];
  logic [31:0] m_cnt[2], m_cmp[2], m_dat[2];
  logic        m_match[2], m_ack[2], m_rd[2];
  int          m_el[2];   // enabled cycles elapsed since the prescaler last restarted

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_ctrl[s] = 3'd0; m_cnt[s] = 32'd0; m_cmp[s] = 32'hFFFF_FFFF; m_dat[s] = 32'd0;
      m_match[s] = 1'b0; m_ack[s] = 1'b0; m_rd[s] = 1'b0; m_el[s] = 0;
    end
  endtask

  task automatic model_step(input int s);
    int          p;
    logic        acc, wr, tk, mt;
    logic [1:0]  r;
    logic [2:0]  c;
    logic [31:0] cnt, cmp;
    p   = (s == 0) ? 1 : 4;
    r   = adr[3:2];
    acc = !m_ack[s] && cyc && ((s == 0) ? stb1 : stb4);
    wr  = acc && we;
    tk  = m_ctrl[s][0] && ((m_el[s] % p) == p - 1);
    c = m_ctrl[s]; cnt = m_cnt[s]; cmp = m_cmp[s];
    mt = m_match[s] && !(wr && r == 2'd3 && dat_i[0]);
    if (tk) begin
      if (m_cnt[s] == m_cmp[s]) begin
        mt = 1'b1;
        if (c[1]) cnt = 32'd0;
        else      c[0] = 1'b0;
      end else begin
        cnt = m_cnt[s] + 32'd1;
      end
    end
    if (acc && !we) begin
      case (r)
        2'd0:    m_dat[s] = {29'd0, m_ctrl[s]};
        2'd1:    m_dat[s] = m_cnt[s];
        2'd2:    m_dat[s] = m_cmp[s];
        default: m_dat[s] = {31'd0, m_match[s]};
      endcase
    end
    if (wr) begin
      case (r)
        2'd0:    c   = dat_i[2:0];
        2'd1:    cnt = dat_i;
        2'd2:    cmp = dat_i;
        default: ;
      endcase
    end
    m_el[s]    = (!m_ctrl[s][0] || (wr && r == 2'd0)) ? 0 : m_el[s] + 1;
    m_ctrl[s]  = c;
    m_cnt[s]   = cnt;
    m_cmp[s]   = cmp;
    m_match[s] = mt;
    m_ack[s]   = acc;
    m_rd[s]    = acc && !we;
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    logic [31:0] d;
    logic        k;
    rst = 1'b1;
    bus_start(2, 1'b1, A_COMPARE, 32'h5);
    step();
    step();
    checks++;
    if ({ack1, ack4, irq1, irq4} !== 4'b0000 || dat1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got ack=%b%b irq=%b%b dat=%h expected all 0", ack1, ack4, irq1, irq4, dat1);
    end
    rst = 1'b0;
    bus_end();
    step();
    for (int s = 0; s < 2; s++) begin
      bus_read(s, A_COMPARE, d, k);
      checks++;
      if (k !== 1'b1 || d !== 32'hFFFF_FFFF) begin
        errors++; $display("FAIL reset_compare s=%0d got ack=%b %h expected ack=1 ffffffff", s, k, d);
      end
      bus_read(s, A_CTRL, d, k);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl s=%0d got %h expected 0", s, d); end
      bus_read(s, A_COUNT, d, k);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_count s=%0d got %h expected 0", s, d); end
      bus_read(s, A_STATUS, d, k);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_status s=%0d got %h expected 0", s, d); end
    end
  endtask

  task automatic test_bus_protocol();
    logic [3:0]  pat;
    logic [31:0] d;
    logic        k, any_ack;
    bus_start(0, 1'b1, A_COMPARE, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      pat[i] = ack1;
      step();
    end
    bus_end();
    step();
    checks++;
    if (pat !== 4'b1010) begin errors++; $display("FAIL held_stb_ack got %b expected 1010 (lsb first cycle)", pat); end
    bus_read(0, A_COMPARE, d, k);
    checks++;
    if (k !== 1'b1 || d !== 32'h1234_5678) begin
      errors++; $display("FAIL read_compare got ack=%b %h expected ack=1 12345678", k, d);
    end
    // strobe without cycle must be ignored, including its write
    any_ack = 1'b0;
    cyc = 1'b0; stb1 = 1'b1; we = 1'b1; adr = A_COMPARE; dat_i = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      any_ack = any_ack | ack1;
    end
    bus_end();
    step();
    checks++;
    if (any_ack !== 1'b0) begin errors++; $display("FAIL stb_without_cyc_ack got %b expected 0", any_ack); end
    bus_read(0, A_COMPARE, d, k);
    checks++;
    if (d !== 32'h1234_5678) begin errors++; $display("FAIL stb_without_cyc_write got %h expected 12345678", d); end
  endtask

  task automatic restart_p1(input logic [31:0] cmp, input logic [31:0] cnt, input logic [2:0] ctrl);
    bus_write(0, A_CTRL, 32'h0);
    bus_write(0, A_STATUS, 32'h1);
    bus_write(0, A_COMPARE, cmp);
    bus_write(0, A_COUNT, cnt);
    bus_write(0, A_CTRL, {29'd0, ctrl});
  endtask

  task automatic test_autoreload();
    logic [31:0] d;
    logic        k;
    // reading w cycles after the enabling write sees (w+1) ticks; period = COMPARE+1
    for (int w = 0; w < 5; w++) begin
      restart_p1(32'd3, 32'd0, 3'b111);
      repeat (w) step();
      bus_read(0, A_COUNT, d, k);
      checks++;
      if (d !== 32'((w + 1) % 4)) begin
        errors++; $display("FAIL reload_count w=%0d got %h expected %h", w, d, 32'((w + 1) % 4));
      end
    end
    restart_p1(32'd3, 32'd0, 3'b111);
    step();
    step();
    checks++;
    if (irq1 !== 1'b0) begin errors++; $display("FAIL reload_irq_early got %b expected 0", irq1); end
    step();
    checks++;
    if (irq1 !== 1'b1) begin errors++; $display("FAIL reload_irq_set got %b expected 1", irq1); end
    bus_read(0, A_STATUS, d, k);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL reload_status got %h expected 1", d); end
    bus_start(0, 1'b1, A_STATUS, 32'h1);
    step();
    checks++;
    if (irq1 !== 1'b0 || ack1 !== 1'b1) begin
      errors++; $display("FAIL w1c_irq got irq=%b ack=%b expected irq=0 ack=1", irq1, ack1);
    end
    bus_end();
    step();
    checks++;
    if (irq1 !== 1'b1) begin errors++; $display("FAIL reload_second_match got %b expected 1", irq1); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    logic        k;
    int          e;
    bus_write(1, A_COMPARE, 32'd2);
    bus_write(1, A_CTRL, 32'h1);
    // read j is accepted 2+2j edges after the enable; data reflects 1+2j edges
    for (int j = 0; j < 8; j++) begin
      bus_read(1, A_COUNT, d, k);
      e = (1 + 2 * j) / 4;
      if (e > 2) e = 2;
      checks++;
      if (d !== 32'(e)) begin errors++; $display("FAIL oneshot_count j=%0d got %h expected %h", j, d, 32'(e)); end
    end
    checks++;
    if (irq4 !== 1'b0) begin errors++; $display("FAIL oneshot_irq got %b expected 0", irq4); end
    bus_read(1, A_CTRL, d, k);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL oneshot_ctrl got %h expected 0", d); end
    bus_read(1, A_STATUS, d, k);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL oneshot_status got %h expected 1", d); end
    repeat (8) step();
    bus_read(1, A_COUNT, d, k);
    checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL oneshot_hold got %h expected 2", d); end
  endtask

  task automatic test_collisions();
    logic [31:0] d;
    logic        k;
    bus_write(1, A_COMPARE, 32'd100);
    bus_write(1, A_CTRL, 32'h1);
    step();
    step();
    bus_write(1, A_COUNT, 32'hA);
    bus_read(1, A_COUNT, d, k);
    checks++;
    if (d !== 32'hA) begin errors++; $display("FAIL count_write_on_tick got %h expected 0000000a", d); end
    bus_write(1, A_CTRL, 32'h0);
    restart_p1(32'd3, 32'd0, 3'b111);
    step();
    step();
    bus_start(0, 1'b1, A_STATUS, 32'h1);
    step();
    checks++;
    if (irq1 !== 1'b1) begin errors++; $display("FAIL w1c_on_match_irq got %b expected 1", irq1); end
    bus_end();
    step();
    bus_read(0, A_STATUS, d, k);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL w1c_on_match_status got %h expected 1", d); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    logic        k;
    restart_p1(32'd5, 32'hFFFF_FFFF, 3'b001);
    bus_read(0, A_COUNT, d, k);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL wrap_count got %h expected 0", d); end
    bus_read(0, A_STATUS, d, k);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL wrap_status got %h expected 0", d); end
    bus_write(0, A_CTRL, 32'h0);
  endtask

  task automatic test_midrun_reset();
    logic [31:0] d;
    logic        k;
    bus_write(0, A_COUNT, 32'd5);
    bus_write(0, A_CTRL, 32'h7);
    checks++;
    if (irq1 !== 1'b1) begin errors++; $display("FAIL prereset_irq got %b expected 1", irq1); end
    rst = 1'b1;
    bus_start(2, 1'b1, A_COMPARE, 32'h55);
    step();
    checks++;
    if ({ack1, ack4, irq1} !== 3'b000 || dat1 !== 32'h0) begin
      errors++; $display("FAIL midrst_outputs got ack=%b%b irq=%b dat=%h expected 0", ack1, ack4, irq1, dat1);
    end
    rst = 1'b0;
    bus_end();
    step();
    for (int s = 0; s < 2; s++) begin
      bus_read(s, A_CTRL, d, k);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL midrst_ctrl s=%0d got %h expected 0", s, d); end
      bus_read(s, A_COUNT, d, k);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL midrst_count s=%0d got %h expected 0", s, d); end
      bus_read(s, A_COMPARE, d, k);
      checks++;
      if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL midrst_compare s=%0d got %h expected ffffffff", s, d); end
      bus_read(s, A_STATUS, d, k);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL midrst_status s=%0d got %h expected 0", s, d); end
    end
  endtask

  task automatic test_random();
    logic [1:0]  r;
    logic [31:0] d;
    logic        got_ack, got_irq;
    logic [31:0] got_dat;
    rst = 1'b1;
    bus_end();
    step();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 600; i++) begin
      if (stb1) begin
        if ($urandom_range(0, 7) != 0) bus_end();
      end else if ($urandom_range(0, 2) == 0) begin
        r = 2'($urandom_range(0, 3));
        case (r)
          2'd1, 2'd2: d = $urandom_range(0, 12);
          default:    d = $urandom;
        endcase
        bus_start(2, 1'($urandom), {4'($urandom), r, 2'($urandom)}, d);
        cyc = ($urandom_range(0, 7) != 0);
      end
      model_step(0);
      model_step(1);
      step();
      for (int s = 0; s < 2; s++) begin
        got_ack = (s == 0) ? ack1 : ack4;
        got_irq = (s == 0) ? irq1 : irq4;
        got_dat = (s == 0) ? dat1 : dat4;
        checks++;
        if (got_ack !== m_ack[s] || got_irq !== (m_match[s] & m_ctrl[s][2])) begin
          errors++;
          $display("FAIL random_ack_irq s=%0d cyc=%0d got ack=%b irq=%b expected ack=%b irq=%b",
                   s, i, got_ack, got_irq, m_ack[s], m_match[s] & m_ctrl[s][2]);
        end
        if (m_rd[s]) begin
          checks++;
          if (got_dat !== m_dat[s]) begin
            errors++; $display("FAIL random_read s=%0d cyc=%0d got %h expected %h", s, i, got_dat, m_dat[s]);
          end
        end
      end
    end
    bus_end();
    step();
  endtask

  initial begin
    test_reset();
    test_bus_protocol();
    test_autoreload();
    test_oneshot();
    test_collisions();
    test_wrap();
    test_midrun_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wshbn_timer_slave.md
# wshbn_timer_slave

Wishbone classic-cycle slave timer occupying slave slot 1 (bus addresses 0x10–0x1F) behind the top-level address/data decoder. It is the responder end of the CPU-side Wishbone master: it acknowledges single read/write cycles to four 32-bit registers. It also runs a prescaled 32-bit up-counter with compare-match, auto-reload or one-shot mode, and a level interrupt toward the interrupt controller.

## Interface
- PRESCALE, 1: counter advances once every PRESCALE clk cycles; legal range 1..65536.
- RESET_COMPARE, 32'hFFFF_FFFF: reset value of COMPARE.
- clk  in  1  system clock; one clock, everything on rising edge.
- rst  in  1  reset is synchronous and active-high.
- CYC_I  in  1  bus cycle valid.
- STB_I  in  1  strobe, already qualified by decoder (CYC & STB & ADR[7:4]==4'b0001).
- WE_I  in  1  1 = write, 0 = read.
- ADR_I  in  8  byte address; only ADR_I[3:2] used; [7:4] and [1:0] ignored.
- DAT_I  in  32  write data.
- DAT_O  out  32  read data, valid while ACK_O = 1.
- ACK_O  out  1  one-cycle acknowledge.
- irq_o  out  1  level interrupt = STATUS.match & CTRL.ien.

## Operation
- Register map (ADR_I[3:2]):
  - 0 CTRL: bit0 en, bit1 reload (1 = auto-reload, 0 = one-shot), bit2 ien; other bits read 0.
  - 1 COUNT: current counter, R/W.
  - 2 COMPARE: match value, R/W.
  - 3 STATUS: bit0 match; write 1 clears, write 0 no effect; other bits read 0.
- Reset values: CTRL=0, COUNT=0, COMPARE=RESET_COMPARE, STATUS=0, prescaler=0, ACK_O=0, DAT_O=0, irq_o=0.
- Bus FSM states:
  - IDLE: on CYC_I&STB_I, go to ACK.
  - ACK: ACK_O=1 for exactly one cycle, then return to IDLE unconditionally.
  - The master must drop STB_I after ACK. A held STB_I produces a new ACK every second cycle, each a separate transfer.
- Write commits on the same edge that raises ACK_O. Read data is registered on that edge from pre-edge register values.
- Tick: prescaler counts 0..PRESCALE-1 while en=1; tick = (prescaler==PRESCALE-1). PRESCALE=1 ticks every cycle with en=1. Prescaler holds at 0 while en=0.
- On tick:
  - If COUNT==COMPARE: set STATUS.match.
    - reload=1: COUNT←0, en stays 1.
    - reload=0: COUNT holds, en←0.
  - Otherwise COUNT←COUNT+1, wrapping 32'hFFFF_FFFF→0 without flag.

## Timing
- Bus latency: ACK_O and DAT_O appear on the edge after STB_I is sampled high (1-cycle wait state). ACK_O is never asserted for two consecutive cycles.
- Register write visible to the counter the cycle after ACK_O rises.
- irq_o is combinational from registered match/ien: high the cycle after the matching tick edge, low the cycle after a W1C.
- Simultaneous events:
  - Bus write to COUNT on a tick edge: bus value wins, tick discarded.
  - Write to CTRL: prescaler cleared to 0 on every CTRL write.
  - W1C of STATUS on a match edge: set wins, match stays 1.
  - One-shot en←0 on the same edge as a CTRL write setting en=1: bus write wins.
- rst mid-cycle: all state to reset values on that edge, any pending ACK dropped. The master must restart the transfer.
- CYC_I low with STB_I high is ignored.

## Structure
- Shared package wshbn_pkg: register offsets (REG_CTRL=2'd0, REG_COUNT=2'd1, REG_COMPARE=2'd2, REG_STATUS=2'd3), CTRL bit indices, bus FSM enum {IDLE, ACK}.
- Sub-module timer_prescaler:
  - Parameter PRESCALE; inputs clk, rst, en, clr; output tick.
  - Counter width $clog2(PRESCALE), minimum 1.
- Top holds the bus FSM, register file, and compare/reload logic.

## Test plan
- Reset: assert rst 2 cycles -> ACK_O=0, irq_o=0; read COMPARE returns 32'hFFFF_FFFF, CTRL reads 0.
- Bus protocol: write 32'h1234_5678 to 0x18 (COMPARE) holding STB_I 4 cycles -> ACK_O pattern 0,1,0,1; read 0x18 returns 32'h1234_5678 with ACK.
- Auto-reload, PRESCALE=1: COMPARE=3, CTRL=3'b111 -> COUNT sequence 0,1,2,3,0; match=1 and irq_o=1 the cycle after COUNT==3 tick; write 1 to STATUS -> irq_o=0.
- One-shot, PRESCALE=4: COMPARE=2, CTRL=3'b001 -> COUNT increments every 4 cycles; after match, CTRL reads 0 and COUNT stays 2; irq_o stays 0 (ien=0).
- Collisions:
  - COUNT write of 32'hA on a tick edge -> COUNT=32'hA next cycle.
  - STATUS W1C on a match edge -> match stays 1.
- Wrap and mid-run reset:
  - COUNT=32'hFFFF_FFFF, COMPARE=5, en=1 -> COUNT=0, no match.
  - Assert rst while ACK_O pending -> ACK_O=0 next cycle, all registers at reset values.
